period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
Measures an asynchronous slow square wave against the system clock, such as the 1 Hz tick from the divider or an external test signal. It reports the period and the high time, both in system-clock cycles. It is the inverse of the divider: a signal produced by dividing by N must read back as period = N. The stopwatch and board self-test use it to check divider output and external tick sources.

Parameters:
COUNT_WIDTH, 28, width of the cycle counter and of the result outputs.
TIMEOUT, 28'd100000000, maximum cycles to wait for an awaited edge (2 s at 50 MHz); must be ≤ 2^COUNT_WIDTH-1.
SYNC_STAGES, 2, flip-flop stages in the input synchronizer; must be ≥ 2.

Ports:
clock  input  1  system clock (50 MHz).
reset  input  1  synchronous, active-high reset.
signal_in  input  1  asynchronous signal to measure.
start  input  1  single-cycle request to begin one measurement.
period  output  COUNT_WIDTH  cycles between two consecutive rising edges.
high_time  output  COUNT_WIDTH  cycles from that rising edge to the following falling edge.
valid  output  1  one-cycle pulse when period and high_time are updated.
busy  output  1  high from the cycle after an accepted start until done or timeout.
timeout  output  1  sticky flag: the last measurement was aborted; cleared by the next accepted start.

Behaviour:
- Reset values: period=0, high_time=0, valid=0, busy=0, timeout=0, state=IDLE, counter=0, synchronizer and edge registers=0.
- Input path:
  - signal_in passes through SYNC_STAGES flops, then one history flop.
  - rise_det = sync & ~hist; fall_det = ~sync & hist.
  - Rising and falling edges see identical latency, so measured intervals are exact.
- IDLE: busy=0. When start=1, go to ARM, set counter=0, clear timeout, busy=1 next cycle. An edge in the same cycle as start is not used.
- ARM: wait for the first rise_det.
  - Counter increments each cycle.
  - On rise_det: counter<=1, go to MEASURE.
  - If counter==TIMEOUT-1 with no rise_det: timeout<=1, go to IDLE.
- MEASURE: counter increments each cycle.
  - On fall_det: high_time_shadow<=counter.
  - On rise_det: period<=counter; high_time<=high_time_shadow (or <=counter if fall_det occurs in the same cycle, which cannot happen legally); valid<=1 for one cycle; go to IDLE.
  - If counter==TIMEOUT with no rise_det: timeout<=1, go to IDLE. period and high_time keep their old values and valid stays 0.
- Timing example: rise_det at cycle t and the next at cycle t+N gives period=N. fall_det at t+H gives high_time=H.
- valid asserts on the cycle the results update; busy drops on that same cycle.
- start while busy is ignored; the measurement continues unaffected.
- A held-high or held-low input reaches timeout and never produces valid.
- The counter never wraps, because TIMEOUT ≤ max count.
- reset mid-measurement: everything returns to reset values next cycle; no valid pulse.
- One measurement per start; back-to-back measurements need a start after each valid or timeout.

Decomposition:
- Shared package (stopwatch_pkg): state encoding IDLE/ARM/MEASURE and the CLOCK_HZ=50000000 constant, also used by the divider's DIVISOR.
- Sub-module edge_synchronizer, parameter SYNC_STAGES.
  - Ports: clock, reset, async_in, level, rise, fall.
  - Reusable for button inputs in the stopwatch.

Test Plan:
1. signal_in square wave, 10 cycles period, high 5; pulse start → valid once, period=10, high_time=5, busy then 0.
2. Square wave period 37, high 3; start → period=37, high_time=3; repeat with a second start → identical result, valid again.
3. TIMEOUT=50, signal_in held 0; start → timeout=1 and busy=0 exactly 50 cycles after ARM entry; no valid; period still 0.
4. Start pulsed again mid-measurement (period 20 wave) → ignored; result period=20. Then start after timeout → timeout cleared in the next cycle.
5. reset asserted during MEASURE → next cycle all outputs 0, state IDLE. A fresh start then measures period 10 correctly.
6. Drive signal_in from the divider with DIVISOR=16 → period=16, high_time=8, proving the divider/meter round trip.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch slice: measurement FSM encoding and the system clock rate.
package stopwatch_pkg;

    localparam int unsigned CLOCK_HZ = 50000000;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } meter_state_t;

endpackage

// File: rtl/edge_synchronizer.sv
// Multi-flop synchronizer for an asynchronous level, with matched-latency rise/fall strobes.
module edge_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Both strobes derive from the same two flops, so edge-to-edge intervals are exact.
    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in system-clock cycles.
module period_meter
    import stopwatch_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 28,
    parameter int unsigned TIMEOUT     = 100000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   signal_in,
    input  logic                   start,
    output logic [COUNT_WIDTH-1:0] period,
    output logic [COUNT_WIDTH-1:0] high_time,
    output logic                   valid,
    output logic                   busy,
    output logic                   timeout
);

    localparam logic [COUNT_WIDTH-1:0] MeasureLimit = COUNT_WIDTH'(TIMEOUT);
    localparam logic [COUNT_WIDTH-1:0] ArmLimit     = COUNT_WIDTH'(TIMEOUT - 1);

    meter_state_t           state;
    logic [COUNT_WIDTH-1:0] counter;
    logic [COUNT_WIDTH-1:0] high_shadow;
    logic                   sync_level;
    logic                   rise_det;
    logic                   fall_det;

    edge_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .async_in(signal_in),
        .level   (sync_level),
        .rise    (rise_det),
        .fall    (fall_det)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            high_shadow <= '0;
            period      <= '0;
            high_time   <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ARM;
                        counter <= '0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ARM: begin
                    if (rise_det) begin
                        counter <= COUNT_WIDTH'(1);
                        state   <= MEASURE;
                    end else if (counter == ArmLimit) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise_det) begin
                        period    <= counter;
                        high_time <= fall_det ? counter : high_shadow;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (counter == MeasureLimit) begin
                        // Abort keeps the previous results untouched.
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        counter <= counter + 1'b1;
                        if (fall_det) begin
                            high_shadow <= counter;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_level;
    assign unused_level = sync_level;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: square waves, timeouts, ignored starts, reset abort, divider loop.
module tb_period_meter;

    localparam int unsigned CW = 28;
    localparam int unsigned TO = 50;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          signal_in;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          busy;
    logic          timeout;

    int checks   = 0;
    int failures = 0;

    // Waveform generator (changes on the falling edge) and a divide-by-16 tick source.
    logic gen_on     = 1'b0;
    logic man_level  = 1'b0;
    logic gen_sig    = 1'b0;
    int   gen_period = 10;
    int   gen_high   = 5;
    int   gen_cnt    = 0;
    logic use_div    = 1'b0;
    logic div_out    = 1'b0;
    int   div_cnt    = 0;

    assign signal_in = use_div ? div_out : gen_sig;

    always #10 clock = ~clock;

    always @(negedge clock) begin
        if (gen_on) begin
            gen_cnt = (gen_cnt + 1 >= gen_period) ? 0 : gen_cnt + 1;
            gen_sig = (gen_cnt < gen_high);
        end else begin
            gen_sig = man_level;
        end
    end

    always @(posedge clock) begin
        if (div_cnt == 7) begin
            div_cnt <= 0;
            div_out <= ~div_out;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    period_meter #(
        .COUNT_WIDTH(CW),
        .TIMEOUT    (TO),
        .SYNC_STAGES(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .signal_in(signal_in),
        .start    (start),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .busy     (busy),
        .timeout  (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    task automatic set_wave(input int p, input int h);
        gen_period = p;
        gen_high   = h;
        gen_on     = 1'b1;
        cycles(p + 4);
    endtask

    // Runs until busy drops, then watches a few more cycles for stray valid pulses.
    task automatic run_meas(input int limit, output int n_valid, output logic expired,
                            output logic [CW-1:0] cap_p, output logic [CW-1:0] cap_h);
        n_valid = 0;
        expired = 1'b1;
        cap_p   = '0;
        cap_h   = '0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (valid === 1'b1) begin
                n_valid++;
                cap_p = period;
                cap_h = high_time;
            end
            if (busy === 1'b0) begin
                expired = 1'b0;
                break;
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (valid === 1'b1) n_valid++;
        end
    endtask

    int            nv;
    logic          exp_flag;
    logic [CW-1:0] cp;
    logic [CW-1:0] ch;

    initial begin
        cycles(4);
        reset = 1'b0;
        @(negedge clock);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);

        // Held low: timeout exactly TO cycles after ARM entry, period untouched.
        gen_on = 1'b0; man_level = 1'b0;
        pulse_start();
        check("t3_busy_on", busy, 1);
        cycles(TO - 1);
        check("t3_pre_timeout", timeout, 0);
        check("t3_pre_busy", busy, 1);
        @(negedge clock);
        check("t3_timeout", timeout, 1);
        check("t3_busy_off", busy, 0);
        check("t3_period", period, 0);
        check("t3_valid", valid, 0);

        // 10-cycle wave, high 5.
        set_wave(10, 5);
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_timeout_clr", timeout, 0);
        run_meas(200, nv, exp_flag, cp, ch);
        check("t1_done", exp_flag, 0);
        check("t1_nvalid", nv, 1);
        check("t1_period", cp, 10);
        check("t1_high", ch, 5);
        check("t1_busy_off", busy, 0);

        // 37-cycle wave, high 3, measured twice.
        set_wave(37, 3);
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            run_meas(200, nv, exp_flag, cp, ch);
            check("t2_done", exp_flag, 0);
            check("t2_nvalid", nv, 1);
            check("t2_period", cp, 37);
            check("t2_high", ch, 3);
        end
        check("t2_timeout", timeout, 0);

        // Extra start mid-measurement must be ignored.
        set_wave(20, 10);
        pulse_start();
        cycles(12);
        pulse_start();
        run_meas(200, nv, exp_flag, cp, ch);
        check("t4_done", exp_flag, 0);
        check("t4_nvalid", nv, 1);
        check("t4_period", cp, 20);
        check("t4_high", ch, 10);

        // Timeout, then a new start clears the flag on the next cycle.
        gen_on = 1'b0; man_level = 1'b1;
        cycles(4);
        pulse_start();
        run_meas(200, nv, exp_flag, cp, ch);
        check("t4_to_done", exp_flag, 0);
        check("t4_to_nvalid", nv, 0);
        check("t4_to_flag", timeout, 1);
        check("t4_to_period", period, 20);
        pulse_start();
        check("t4_to_clear", timeout, 0);
        check("t4_to_busy", busy, 1);
        run_meas(200, nv, exp_flag, cp, ch);
        check("t4_to2_flag", timeout, 1);

        // Reset while in MEASURE.
        man_level = 1'b0;
        cycles(4);
        pulse_start();
        cycles(3);
        man_level = 1'b1;
        cycles(8);
        check("t5_busy_meas", busy, 1);
        @(negedge clock) reset = 1'b1;
        @(negedge clock);
        check("t5_period", period, 0);
        check("t5_high", high_time, 0);
        check("t5_valid", valid, 0);
        check("t5_busy", busy, 0);
        check("t5_timeout", timeout, 0);
        reset = 1'b0;
        set_wave(10, 5);
        pulse_start();
        run_meas(200, nv, exp_flag, cp, ch);
        check("t5_nvalid", nv, 1);
        check("t5_period2", cp, 10);
        check("t5_high2", ch, 5);

        // Divider-by-16 round trip.
        use_div = 1'b1;
        cycles(40);
        pulse_start();
        run_meas(200, nv, exp_flag, cp, ch);
        check("t6_done", exp_flag, 0);
        check("t6_nvalid", nv, 1);
        check("t6_period", cp, 16);
        check("t6_high", ch, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
